// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   Parameterizable D flip-flop delay line. With the default configuration
//   (WIDTH=1, DEPTH=1) it is a single D flip-flop. Larger configurations form a
//   DEPTH-stage shift pipeline. The pipeline has per-stage valid tracking, a
//   global shift enable, a synchronous clear, a selectable tap and an in-flight
//   count.
//
// Parameters
//   WIDTH      data bit width of din/dout/tap_out
//   DEPTH      number of register stages (>=1), latency in enabled cycles
//   RESET_VAL  value loaded into every data stage on reset and on clr
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous reset, active-low
//   en         shift enable (1 = advance, 0 = hold)
//   clr        synchronous clear, takes priority over en
//   din        data into stage 0
//   din_vld    valid tag captured alongside din
//   dout       data of the last stage (registered)
//   dout_vld   valid bit of the last stage
//   tap_sel    stage index for tap_out; any value >= DEPTH selects the last stage
//   tap_out    data of the selected stage (mux of registers only)
//   in_flight  number of stages currently holding a valid entry
// -----------------------------------------------------------------------------
module dff_pipe #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     SW        = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [SW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_out,
    output logic [SW-1:0]    in_flight
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_tap;

    // The in-flight count is kept as its own register and is updated
    // incrementally. It gains the entering valid and loses the one shifted
    // out of the last stage. This equals the popcount of r_vld without
    // needing an adder tree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_vld <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_vld <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_data[0] <= din;
            r_vld[0]  <= din_vld;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
            r_cnt <= r_cnt + SW'(din_vld) - SW'(r_vld[DEPTH-1]);
        end
    end

    // Default to the last stage so that out-of-range selects alias dout.
    always_comb begin
        w_tap = r_data[DEPTH-1];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap_sel == SW'(i)) begin
                w_tap = r_data[i];
            end
        end
    end

    assign dout      = r_data[DEPTH-1];
    assign dout_vld  = r_vld[DEPTH-1];
    assign tap_out   = w_tap;
    assign in_flight = r_cnt;

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

    logic clk = 1'b0;
    logic rst;

    // Default configuration: a single flip-flop
    logic en1, clr1, din1, vld1, tap1;
    logic dout1, dv1, tapo1, inf1;

    // DEPTH=4, WIDTH=8, RESET_VAL=0xA5
    logic       en4, clr4, vld4;
    logic [7:0] din4;
    logic [2:0] tap4;
    logic [7:0] dout4, tapo4;
    logic       dv4;
    logic [2:0] inf4;

    dff_pipe u_d1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr1), .din(din1), .din_vld(vld1),
        .dout(dout1), .dout_vld(dv1), .tap_sel(tap1), .tap_out(tapo1),
        .in_flight(inf1)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d4 (
        .clk(clk), .rst(rst), .en(en4), .clr(clr4), .din(din4), .din_vld(vld4),
        .dout(dout4), .dout_vld(dv4), .tap_sel(tap4), .tap_out(tapo4),
        .in_flight(inf4)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } ent_t;

    // Reference state. m4[0] is stage 0 and m4[3] is the output stage.
    logic       m1_d, m1_v;
    ent_t       m4[$];
    logic [7:0] sbq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset4();
        m4.delete();
        for (int i = 0; i < 4; i++) m4.push_back('{8'hA5, 1'b0});
        sbq.delete();
    endtask

    task automatic model_reset();
        m1_d = 1'b0;
        m1_v = 1'b0;
        reset4();
    endtask

    task automatic check_all();
        int cnt;
        int idx;
        chk("d1_dout", 32'(dout1), 32'(m1_d));
        chk("d1_vld", 32'(dv1), 32'(m1_v));
        chk("d1_inflight", 32'(inf1), 32'(m1_v));
        chk("d1_tap", 32'(tapo1), 32'(m1_d));
        cnt = 0;
        foreach (m4[i]) if (m4[i].v) cnt++;
        idx = (tap4 >= 3'd4) ? 3 : int'(tap4);
        chk("d4_dout", 32'(dout4), 32'(m4[3].d));
        chk("d4_vld", 32'(dv4), 32'(m4[3].v));
        chk("d4_inflight", 32'(inf4), 32'(cnt));
        chk("d4_tap", 32'(tapo4), 32'(m4[idx].d));
    endtask

    // One clock: apply the spec rules to the model at the edge. Then check
    // just after the edge, and return at the next falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (clr1) begin
                m1_d = 1'b0;
                m1_v = 1'b0;
            end else if (en1) begin
                m1_d = din1;
                m1_v = vld1;
            end
            if (clr4) begin
                reset4();
            end else if (en4) begin
                if (vld4) sbq.push_back(din4);
                m4.push_front('{din4, vld4});
                void'(m4.pop_back());
            end
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Scoreboard monitor. A new output appears on every enabled,
    // non-cleared edge. If that output is tagged valid, it must be the
    // oldest valid sample still outstanding.
    always @(posedge clk) begin : mon
        logic fire;
        logic [7:0] e;
        fire = rst && en4 && !clr4;
        #1;
        if (fire && dv4) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got %0h expected none at %0t", dout4, $time);
            end else begin
                e = sbq.pop_front();
                chk("sb_dout", 32'(dout4), 32'(e));
            end
        end
    end

    logic [7:0] fill [4]   = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       seq1 [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] tsel [6]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    logic [7:0] texp [6]   = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h11, 8'h11};

    initial begin
        rst  = 1'b1;
        en1  = 1'b0; clr1 = 1'b0; din1 = 1'b0; vld1 = 1'b0; tap1 = 1'b0;
        en4  = 1'b0; clr4 = 1'b0; din4 = '0;   vld4 = 1'b0; tap4 = '0;
        #1 rst = 1'b0;
        #2;
        model_reset();
        check_all();

        // Edges while in reset must not capture anything
        en1 = 1'b1; din1 = 1'b1; vld1 = 1'b1;
        en4 = 1'b1; din4 = 8'hFF; vld4 = 1'b1;
        repeat (3) cyc();
        rst = 1'b1;

        // Fill both pipelines
        for (int k = 0; k < 4; k++) begin
            din1 = seq1[k];
            din4 = fill[k];
            vld4 = 1'b1;
            cyc();
        end

        // Pipeline full: hold, then tap sweep without a clock edge
        en4 = 1'b0;
        #1;
        chk("full_dout", 32'(dout4), 32'h11);
        chk("full_inflight", 32'(inf4), 32'd4);
        for (int k = 0; k < 6; k++) begin
            tap4 = tsel[k];
            #1;
            chk("tap_const", 32'(tapo4), 32'(texp[k]));
        end

        // Hold for 3 cycles, then resume and drain with invalid input
        repeat (3) begin
            din4 = 8'($urandom);
            din1 = 1'($urandom);
            cyc();
        end
        en4 = 1'b1;
        vld4 = 1'b0;
        repeat (4) begin
            din4 = 8'($urandom);
            cyc();
        end

        // Refill, then clear with en=1 and a valid input present
        vld4 = 1'b1;
        repeat (4) begin
            din4 = 8'($urandom);
            cyc();
        end
        clr4 = 1'b1;
        din4 = 8'h99;
        cyc();
        chk("clr_inflight", 32'(inf4), 32'd0);
        chk("clr_dout", 32'(dout4), 32'hA5);
        clr4 = 1'b0;

        // Randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 300; i++) begin
            en1  = ($urandom_range(0, 9) < 7);
            clr1 = ($urandom_range(0, 19) == 0);
            din1 = 1'($urandom);
            vld1 = 1'($urandom);
            tap1 = 1'($urandom);
            en4  = ($urandom_range(0, 9) < 7);
            clr4 = ($urandom_range(0, 19) == 0);
            din4 = 8'($urandom);
            vld4 = ($urandom_range(0, 3) != 0);
            tap4 = 3'($urandom_range(0, 7));
            cyc();
            if (i == 150) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all();
                cyc();
                rst = 1'b1;
            end
        end

        // Drain everything still outstanding
        en4 = 1'b1; clr4 = 1'b0; vld4 = 1'b0;
        repeat (5) cyc();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
